// File: rtl/poly_sub_coeff_engine.sv
// Sequential coefficient-wise modular subtractor c[i] = (a[i] - b[i]) mod Q.
// Streams N coefficient pairs from two BRAMs through a fixed 3-cycle pipeline into a result BRAM.
module poly_sub_coeff_engine #(
    parameter int unsigned N  = 1024,
    parameter int unsigned AW = 10,
    parameter int unsigned Q  = 12289
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [15:0]   dia,
    input  logic [15:0]   dib,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [15:0]   dout
);

    localparam int unsigned DW = 16;
    localparam int unsigned SW = 15;
    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);
    localparam logic [SW-1:0] Q_S       = SW'(Q);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            rd_en_q, rd_en_d;
    logic [AW-1:0]   rd_addr_q, rd_addr_d;
    logic            v1_q, v1_d;
    logic [AW-1:0]   a1_q, a1_d;
    logic            v2_q, v2_d;
    logic [AW-1:0]   a2_q, a2_d;
    logic [SW-1:0]   s1_q, s1_d;
    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [DW-1:0]   dout_q, dout_d;

    // Control: issue reads, wait for the last write to leave stage 2, then pulse done.
    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RUN;
                    busy_d    = 1'b1;
                    rd_en_d   = 1'b1;
                    rd_addr_d = '0;
                end
            end
            S_RUN: begin
                if (rd_addr_q == LAST_ADDR) begin
                    state_d = S_DRAIN;
                end else begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = rd_addr_q + AW'(1);
                end
            end
            S_DRAIN: begin
                // DONE is entered while the final write is still being registered,
                // so IDLE coincides with the done pulse and can take a new start.
                if (v2_q && (a2_q == LAST_ADDR)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: a + Q - b never underflows and stays below 2Q, so one conditional subtract reduces it.
    always_comb begin
        v1_d      = rd_en_q;
        a1_d      = rd_addr_q;
        v2_d      = v1_q;
        a2_d      = a1_q;
        s1_d      = v1_q ? (SW'(dia) + Q_S - SW'(dib)) : s1_q;
        wr_en_d   = v2_q;
        wr_addr_d = v2_q ? a2_q : wr_addr_q;
        dout_d    = dout_q;
        if (v2_q) begin
            dout_d = (s1_q >= Q_S) ? DW'(s1_q - Q_S) : DW'(s1_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            v1_q      <= 1'b0;
            a1_q      <= '0;
            v2_q      <= 1'b0;
            a2_q      <= '0;
            s1_q      <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            dout_q    <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            v1_q      <= v1_d;
            a1_q      <= a1_d;
            v2_q      <= v2_d;
            a2_q      <= a2_d;
            s1_q      <= s1_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            dout_q    <= dout_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign dout    = dout_q;

endmodule

// File: tb/tb_poly_sub_coeff_engine.sv
// Bench for poly_sub_coeff_engine: an N=8 instance for corners/timing and an N=1024 instance
// for mid-pass reset and random passes, each fed by 1-cycle-latency BRAM models.
module tb_poly_sub_coeff_engine;

    localparam int unsigned Q   = 12289;
    localparam int unsigned N8  = 8;
    localparam int unsigned AW8 = 3;
    localparam int unsigned NK  = 1024;
    localparam int unsigned AWK = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start8, startk;

    logic           busy8, done8, rd_en8, wr_en8;
    logic [AW8-1:0] rd_addr8, wr_addr8;
    logic [15:0]    dia8, dib8, dout8;

    logic           busyk, donek, rd_enk, wr_enk;
    logic [AWK-1:0] rd_addrk, wr_addrk;
    logic [15:0]    diak, dibk, doutk;

    logic [15:0] ma8[N8], mb8[N8];
    logic [15:0] mak[NK], mbk[NK];

    int checks = 0;
    int passed = 0;

    poly_sub_coeff_engine #(.N(N8), .AW(AW8), .Q(Q)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .busy(busy8), .done(done8),
        .rd_en(rd_en8), .rd_addr(rd_addr8), .dia(dia8), .dib(dib8),
        .wr_en(wr_en8), .wr_addr(wr_addr8), .dout(dout8)
    );

    poly_sub_coeff_engine #(.N(NK), .AW(AWK), .Q(Q)) dutk (
        .clk(clk), .rst_n(rst_n), .start(startk), .busy(busyk), .done(donek),
        .rd_en(rd_enk), .rd_addr(rd_addrk), .dia(diak), .dib(dibk),
        .wr_en(wr_enk), .wr_addr(wr_addrk), .dout(doutk)
    );

    always @(posedge clk) begin
        if (rd_en8) begin
            dia8 <= ma8[rd_addr8];
            dib8 <= mb8[rd_addr8];
        end
        if (rd_enk) begin
            diak <= mak[rd_addrk];
            dibk <= mbk[rd_addrk];
        end
    end

    // Reference: mathematical (a - b) mod Q with signed integer arithmetic.
    function automatic logic [15:0] ref_sub(input int a, input int b);
        int d;
        d = (a - b) % int'(Q);
        if (d < 0) d = d + int'(Q);
        return 16'(d);
    endfunction

    task automatic test_reset();
        rst_n  = 1'b0;
        start8 = 1'b1;
        startk = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (busy8 !== 1'b0)   $display("FAIL reset_busy8 got %b exp 0", busy8);   else passed++;
        checks++; if (done8 !== 1'b0)   $display("FAIL reset_done8 got %b exp 0", done8);   else passed++;
        checks++; if (rd_en8 !== 1'b0)  $display("FAIL reset_rd_en8 got %b exp 0", rd_en8); else passed++;
        checks++; if (wr_en8 !== 1'b0)  $display("FAIL reset_wr_en8 got %b exp 0", wr_en8); else passed++;
        checks++; if (dout8 !== 16'd0)  $display("FAIL reset_dout8 got %0d exp 0", dout8);  else passed++;
        checks++; if (busyk !== 1'b0)   $display("FAIL reset_busyk got %b exp 0", busyk);   else passed++;
        checks++; if (rd_enk !== 1'b0)  $display("FAIL reset_rd_enk got %b exp 0", rd_enk); else passed++;
        checks++; if (wr_enk !== 1'b0)  $display("FAIL reset_wr_enk got %b exp 0", wr_enk); else passed++;
        checks++; if (rd_addrk !== '0)  $display("FAIL reset_rd_addrk got %0d exp 0", rd_addrk); else passed++;
        rst_n  = 1'b1;
        start8 = 1'b0;
        startk = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy8 !== 1'b0)  $display("FAIL post_reset_busy8 got %b exp 0", busy8);   else passed++;
        checks++; if (rd_enk !== 1'b0) $display("FAIL post_reset_rd_enk got %b exp 0", rd_enk); else passed++;
    endtask

    // One N=8 pass with per-cycle timing checks; start sampled at edge 0, observed through cycle 13.
    task automatic run8(input bit hold, output int nwr, output logic [15:0] got[N8]);
        bit exp_rd, exp_wr, exp_busy, exp_done;
        nwr = 0;
        for (int i = 0; i < int'(N8); i++) got[i] = 16'hxxxx;
        @(negedge clk);
        start8 = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            if (c == 1 && !hold) start8 = 1'b0;
            exp_rd   = (c <= 8) || (hold && c == 13);
            exp_busy = (c <= 11) || (hold && c == 13);
            exp_wr   = (c >= 4) && (c <= 11);
            exp_done = (c == 12);
            checks++; if (rd_en8 !== exp_rd)   $display("FAIL t%0d_rd_en got %b exp %b", c, rd_en8, exp_rd);   else passed++;
            checks++; if (busy8 !== exp_busy)  $display("FAIL t%0d_busy got %b exp %b", c, busy8, exp_busy);  else passed++;
            checks++; if (wr_en8 !== exp_wr)   $display("FAIL t%0d_wr_en got %b exp %b", c, wr_en8, exp_wr);   else passed++;
            checks++; if (done8 !== exp_done)  $display("FAIL t%0d_done got %b exp %b", c, done8, exp_done);   else passed++;
            if (exp_rd) begin
                checks++;
                if (rd_addr8 !== AW8'((c == 13) ? 0 : c - 1))
                    $display("FAIL t%0d_rd_addr got %0d exp %0d", c, rd_addr8, (c == 13) ? 0 : c - 1);
                else passed++;
            end
            if (wr_en8 === 1'b1) begin
                nwr++;
                got[wr_addr8] = dout8;
                checks++;
                if (wr_addr8 !== AW8'(c - 4)) $display("FAIL t%0d_wr_addr got %0d exp %0d", c, wr_addr8, c - 4);
                else passed++;
                checks++;
                if (dout8 !== ref_sub(int'(ma8[c-4]), int'(mb8[c-4])))
                    $display("FAIL t%0d_dout got %0d exp %0d", c, dout8, ref_sub(int'(ma8[c-4]), int'(mb8[c-4])));
                else passed++;
            end
        end
    endtask

    task automatic test_corners_timing();
        int ca[8], cb[8], ce[8];
        int nwr;
        logic [15:0] got[N8];
        ca = '{5, 3, 100, 12288, 0, 0, 6144, 1};
        cb = '{3, 5, 100, 0, 12288, 0, 6145, 12288};
        ce = '{2, 12287, 0, 12288, 1, 0, 12288, 2};
        for (int i = 0; i < 8; i++) begin
            ma8[i] = 16'(ca[i]);
            mb8[i] = 16'(cb[i]);
        end
        run8(1'b0, nwr, got);
        checks++; if (nwr != 8) $display("FAIL corner_write_count got %0d exp 8", nwr); else passed++;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got[i] !== 16'(ce[i])) $display("FAIL corner_c%0d got %0d exp %0d", i, got[i], ce[i]);
            else passed++;
        end
    endtask

    task automatic test_start_held();
        int nwr;
        int done_c;
        logic [15:0] got[N8];
        for (int i = 0; i < 8; i++) begin
            ma8[i] = 16'($urandom_range(Q - 1, 0));
            mb8[i] = 16'($urandom_range(Q - 1, 0));
        end
        run8(1'b1, nwr, got);
        start8 = 1'b0;
        checks++; if (nwr != 8) $display("FAIL held_write_count got %0d exp 8", nwr); else passed++;
        // Second pass started at edge 12, so its done lands in cycle 24.
        done_c = -1;
        for (int c = 14; c <= 40; c++) begin
            @(negedge clk);
            if (done8 === 1'b1 && done_c < 0) done_c = c;
        end
        checks++; if (done_c != 24) $display("FAIL held_second_done got cycle %0d exp 24", done_c); else passed++;
    endtask

    task automatic fill_k();
        for (int i = 0; i < int'(NK); i++) begin
            mak[i] = 16'($urandom_range(Q - 1, 0));
            mbk[i] = 16'($urandom_range(Q - 1, 0));
        end
    endtask

    task automatic run_pass_k(input int pass_id);
        int nwr;
        int done_c;
        bit busy_after;
        fill_k();
        nwr = 0;
        done_c = -1;
        busy_after = 1'b0;
        @(negedge clk);
        startk = 1'b1;
        for (int c = 1; c <= int'(NK) + 8; c++) begin
            @(negedge clk);
            if (c == 1) startk = 1'b0;
            if (wr_enk === 1'b1) begin
                checks++;
                if (wr_addrk !== AWK'(nwr))
                    $display("FAIL p%0d_wr_addr got %0d exp %0d", pass_id, wr_addrk, nwr);
                else passed++;
                checks++;
                if (doutk !== ref_sub(int'(mak[nwr]), int'(mbk[nwr])))
                    $display("FAIL p%0d_dout[%0d] got %0d exp %0d", pass_id, nwr, doutk, ref_sub(int'(mak[nwr]), int'(mbk[nwr])));
                else passed++;
                nwr++;
            end
            if (donek === 1'b1 && done_c < 0) done_c = c;
            if (c == int'(NK) + 4 && busyk !== 1'b0) busy_after = 1'b1;
        end
        checks++; if (nwr != int'(NK)) $display("FAIL p%0d_write_count got %0d exp %0d", pass_id, nwr, NK); else passed++;
        checks++; if (done_c != int'(NK) + 4) $display("FAIL p%0d_done_cycle got %0d exp %0d", pass_id, done_c, NK + 4); else passed++;
        checks++; if (busy_after) $display("FAIL p%0d_busy_at_done got 1 exp 0", pass_id); else passed++;
    endtask

    task automatic test_reset_mid_pass();
        fill_k();
        @(negedge clk);
        startk = 1'b1;
        for (int c = 1; c <= 1100; c++) begin
            @(negedge clk);
            if (c == 1) startk = 1'b0;
            if (c == 500) rst_n = 1'b0;
            if (c == 502) rst_n = 1'b1;
            if (c >= 501) begin
                checks++; if (wr_enk !== 1'b0) $display("FAIL midrst_wr_en c%0d got %b exp 0", c, wr_enk); else passed++;
                checks++; if (donek !== 1'b0)  $display("FAIL midrst_done c%0d got %b exp 0", c, donek);  else passed++;
            end
        end
        run_pass_k(-1);
    endtask

    task automatic test_random_passes();
        for (int p = 0; p < 50; p++) run_pass_k(p);
    endtask

    initial begin
        test_reset();
        test_corners_timing();
        test_start_held();
        test_reset_mid_pass();
        test_random_passes();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
